// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point helpers for the RNN datapath.
// Holds the Q(QN.QM) width derivations, the log2 helper, the default
// saturation bounds, the shift-then-clamp used by the output layer, and
// the dense_output_layer FSM encoding.
package rnn_fixed_pkg;

    // Working width for sat_shift; every accumulator must fit inside it.
    localparam int unsigned SAT_W         = 64;
    localparam int unsigned DEF_QN        = 6;
    localparam int unsigned DEF_QM        = 11;
    localparam int unsigned DEF_BITWIDTH  = DEF_QN + DEF_QM + 1;

    localparam logic signed [SAT_W-1:0] SAT_MAX =
        (SAT_W'(1) << (DEF_BITWIDTH - 1)) - SAT_W'(1);
    localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } dense_state_e;

    // Ceiling log2 of value.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned bitwidth(input int unsigned qn, input int unsigned qm);
        return qn + qm + 1;
    endfunction

    // Wide enough that bias<<<QM plus hidden_sz full products cannot overflow.
    function automatic int unsigned acc_width(input int unsigned bw, input int unsigned hidden_sz);
        return 2 * bw + log2(hidden_sz) + 1;
    endfunction

    // Arithmetic floor by qm, then clamp to a signed bw-bit range.
    function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                          input int unsigned             qm,
                                                          input int unsigned             bw);
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        shifted = acc >>> qm;
        hi      = (SAT_W'(1) << (bw - 1)) - SAT_W'(1);
        lo      = ~hi;
        if (shifted > hi)      return hi;
        else if (shifted < lo) return lo;
        else                   return shifted;
    endfunction

endpackage

// File: rtl/output_mac.sv
// One multiply-accumulate lane of the dense output layer.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   load_i        - preload accumulator with bias <<< QM
//   acc_en_i      - add weight_i * hidden_i to the accumulator
//   last_i        - final product this cycle; register the saturated result
//   bias_i        - signed bias word
//   weight_i      - signed weight W[r][col]
//   hidden_i      - signed hidden word h[col]
//   result_o      - registered sat(acc >>> QM), held until the next last_i
module output_mac
    import rnn_fixed_pkg::*;
#(
    parameter int unsigned BITWIDTH = 18,
    parameter int unsigned QM       = 11,
    parameter int unsigned ACC_W    = 41
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_i,
    input  logic                acc_en_i,
    input  logic                last_i,
    input  logic [BITWIDTH-1:0] bias_i,
    input  logic [BITWIDTH-1:0] weight_i,
    input  logic [BITWIDTH-1:0] hidden_i,
    output logic [BITWIDTH-1:0] result_o
);

    localparam int unsigned PROD_W = 2 * BITWIDTH;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  bias_acc_c;
    logic signed [ACC_W-1:0]  acc_sum_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [BITWIDTH-1:0]      result_q;
    logic [BITWIDTH-1:0]      result_d;

    // Full-precision product and running sum; the shift is applied only to the total.
    always_comb begin
        prod_c     = $signed(weight_i) * $signed(hidden_i);
        acc_sum_c  = acc_q + ACC_W'(prod_c);
        bias_acc_c = ACC_W'($signed(bias_i)) <<< QM;

        acc_d = acc_q;
        if (load_i)        acc_d = bias_acc_c;
        else if (acc_en_i) acc_d = acc_sum_c;

        result_d = result_q;
        if (last_i) result_d = BITWIDTH'(sat_shift(SAT_W'(acc_sum_c), QM, BITWIDTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/dense_output_layer.sv
// Fully-connected output stage: y = sat((W*h + b) >>> QM), one lane per output row.
// Ports:
//   clock, reset  - clock and synchronous active-high reset
//   hiddenVec     - HIDDEN_SZ signed words, latched on acceptance
//   hiddenValid   - request, accepted only in IDLE
//   colAddr/colData/colWriteEn - weight column write port (IDLE only)
//   biasData/biasWriteEn       - bias write port (IDLE only)
//   busy          - high from the cycle after acceptance through the result cycle
//   dataoutReady  - one-cycle pulse marking a new outputVec
//   outputVec     - OUTPUT_SZ saturated signed words, held until the next result
module dense_output_layer
    import rnn_fixed_pkg::*;
#(
    parameter int unsigned HIDDEN_SZ = 16,
    parameter int unsigned OUTPUT_SZ = 1,
    parameter int unsigned QN        = 6,
    parameter int unsigned QM        = 11,
    localparam int unsigned BITWIDTH = bitwidth(QN, QM),
    localparam int unsigned COL_W    = (log2(HIDDEN_SZ) > 0) ? log2(HIDDEN_SZ) : 1,
    localparam int unsigned ROW_W    = OUTPUT_SZ * BITWIDTH,
    localparam int unsigned VEC_W    = HIDDEN_SZ * BITWIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [VEC_W-1:0] hiddenVec,
    input  logic             hiddenValid,
    input  logic [COL_W-1:0] colAddr,
    input  logic [ROW_W-1:0] colData,
    input  logic             colWriteEn,
    input  logic [ROW_W-1:0] biasData,
    input  logic             biasWriteEn,
    output logic             busy,
    output logic             dataoutReady,
    output logic [ROW_W-1:0] outputVec
);

    localparam int unsigned ACC_W = acc_width(BITWIDTH, HIDDEN_SZ);

    dense_state_e        state_q;
    logic [COL_W-1:0]    col_q;
    logic [VEC_W-1:0]    hid_q;
    logic [ROW_W-1:0]    w_q [HIDDEN_SZ];
    logic [ROW_W-1:0]    bias_q;
    logic                busy_q;
    logic                ready_q;

    logic                accept_c;
    logic                mac_en_c;
    logic                last_c;
    logic [ROW_W-1:0]    bias_sel_c;
    logic [ROW_W-1:0]    w_col_c;
    logic [BITWIDTH-1:0] h_word_c;

    // Lane controls and combinational register-file reads.
    always_comb begin
        accept_c   = (state_q == ST_IDLE) && hiddenValid;
        mac_en_c   = (state_q == ST_MAC);
        last_c     = mac_en_c && (col_q == COL_W'(HIDDEN_SZ - 1));
        // A bias written in the acceptance cycle is the one preloaded.
        bias_sel_c = biasWriteEn ? biasData : bias_q;
        w_col_c    = w_q[col_q];
        h_word_c   = hid_q[col_q*BITWIDTH +: BITWIDTH];
    end

    // FSM, column counter, hidden latch and register file.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            hid_q   <= '0;
            bias_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k < int'(HIDDEN_SZ); k++) w_q[k] <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (colWriteEn)  w_q[colAddr] <= colData;
                    if (biasWriteEn) bias_q <= biasData;
                    if (hiddenValid) begin
                        hid_q   <= hiddenVec;
                        col_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    col_q <= col_q + COL_W'(1);
                    // Lanes register the result on this edge, so the pulse lines up with it.
                    if (last_c) begin
                        ready_q <= 1'b1;
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < int'(OUTPUT_SZ); r++) begin : g_lane
        output_mac #(
            .BITWIDTH (BITWIDTH),
            .QM       (QM),
            .ACC_W    (ACC_W)
        ) u_mac (
            .clock    (clock),
            .reset    (reset),
            .load_i   (accept_c),
            .acc_en_i (mac_en_c),
            .last_i   (last_c),
            .bias_i   (bias_sel_c[r*BITWIDTH +: BITWIDTH]),
            .weight_i (w_col_c[r*BITWIDTH +: BITWIDTH]),
            .hidden_i (h_word_c),
            .result_o (outputVec[r*BITWIDTH +: BITWIDTH])
        );
    end

    assign busy         = busy_q;
    assign dataoutReady = ready_q;

endmodule

// File: tb/tb_dense_output_layer.sv
// Directed bench for dense_output_layer with a scoreboard of expected outputs.
module tb_dense_output_layer;

    localparam int unsigned H  = 16;
    localparam int unsigned BW = 18;
    localparam int unsigned AW = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [H*BW-1:0] hiddenVec;
    logic            hiddenValid;
    logic [AW-1:0]   colAddr;
    logic [BW-1:0]   colData;
    logic            colWriteEn;
    logic [BW-1:0]   biasData;
    logic            biasWriteEn;
    logic            busy;
    logic            dataoutReady;
    logic [BW-1:0]   outputVec;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint exp_q[$];
    int     w_m[H];
    int     h_m[H];
    int     b_m;

    dense_output_layer #(.HIDDEN_SZ(16), .OUTPUT_SZ(1), .QN(6), .QM(11)) dut (
        .clock        (clock),
        .reset        (reset),
        .hiddenVec    (hiddenVec),
        .hiddenValid  (hiddenValid),
        .colAddr      (colAddr),
        .colData      (colData),
        .colWriteEn   (colWriteEn),
        .biasData     (biasData),
        .biasWriteEn  (biasWriteEn),
        .busy         (busy),
        .dataoutReady (dataoutReady),
        .outputVec    (outputVec)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact integer dot product, floor shift of the total, clamp.
    function automatic longint model();
        longint acc;
        acc = longint'(b_m) * 2048;
        for (int k = 0; k < int'(H); k++) acc += longint'(w_m[k]) * longint'(h_m[k]);
        acc = acc >>> 11;
        if (acc > 131071)  acc = 131071;
        if (acc < -131072) acc = -131072;
        return acc;
    endfunction

    task automatic drive_h();
        for (int k = 0; k < int'(H); k++) hiddenVec[k*BW +: BW] = BW'(h_m[k]);
    endtask

    task automatic write_w();
        for (int k = 0; k < int'(H); k++) begin
            colAddr    = AW'(k);
            colData    = BW'(w_m[k]);
            colWriteEn = 1'b1;
            step();
        end
        colWriteEn = 1'b0;
    endtask

    task automatic write_b();
        biasData    = BW'(b_m);
        biasWriteEn = 1'b1;
        step();
        biasWriteEn = 1'b0;
    endtask

    // Issue one request; optionally inject a request plus writes at MAC cycle 4.
    task automatic run_vec(input string tag, input bit inject);
        int     cnt;
        int     extra;
        bit     busy_ok;
        longint exp;
        drive_h();
        hiddenValid = 1'b1;
        exp_q.push_back(model());
        step();
        hiddenValid = 1'b0;
        cnt     = 1;
        busy_ok = 1'b1;
        while (dataoutReady !== 1'b1 && cnt < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject && cnt == 4) begin
                hiddenValid = 1'b1;
                hiddenVec   = '1;
                colAddr     = AW'(3);
                colData     = BW'(12345);
                colWriteEn  = 1'b1;
                biasData    = BW'(-999);
                biasWriteEn = 1'b1;
            end else begin
                hiddenValid = 1'b0;
                colWriteEn  = 1'b0;
                biasWriteEn = 1'b0;
            end
            step();
            cnt++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
        check({tag, "_latency"}, cnt, 17);
        check({tag, "_busy_high"}, busy_ok, 1);
        exp = exp_q.pop_front();
        check({tag, "_result"}, $signed(outputVec), exp);
        step();
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_ready_low"}, dataoutReady, 0);
        if (inject) begin
            extra = 0;
            repeat (20) begin
                if (dataoutReady === 1'b1) extra++;
                step();
            end
            check({tag, "_no_second_ready"}, extra, 0);
            check({tag, "_result_held"}, $signed(outputVec), exp);
        end
    endtask

    initial begin
        int ready_seen;
        reset       = 1'b1;
        hiddenVec   = '0;
        hiddenValid = 1'b0;
        colAddr     = '0;
        colData     = '0;
        colWriteEn  = 1'b0;
        biasData    = '0;
        biasWriteEn = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_output", $signed(outputVec), 0);
        check("reset_busy", busy, 0);
        check("reset_ready", dataoutReady, 0);

        // Basic sum: 16 * 1.0 * 0.5 = 8.0
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 2048; h_m[k] = 1024; end
        b_m = 0;
        write_w(); write_b();
        run_vec("basic", 1'b0);

        // Bias only
        for (int k = 0; k < int'(H); k++) w_m[k] = 0;
        b_m = -3072;
        write_w(); write_b();
        run_vec("bias_only", 1'b0);

        // Positive and negative saturation
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 63488; h_m[k] = 63488; end
        b_m = 0;
        write_w(); write_b();
        run_vec("sat_pos", 1'b0);
        for (int k = 0; k < int'(H); k++) w_m[k] = -63488;
        write_w();
        run_vec("sat_neg", 1'b0);

        // Floor applies to the whole sum
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 0; h_m[k] = 0; end
        w_m[0] = 1; h_m[0] = -1;
        write_w();
        run_vec("floor_neg", 1'b0);
        w_m[0] = 1024; w_m[1] = 1024; h_m[0] = 1; h_m[1] = 1;
        write_w();
        run_vec("floor_sum", 1'b0);

        // Request and writes while busy are ignored
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 100 * k + 1; h_m[k] = (k - 8) * 640; end
        b_m = 77;
        write_w(); write_b();
        run_vec("busy_inject", 1'b1);
        run_vec("busy_rerun", 1'b0);

        // Same-cycle write with acceptance is used by that computation
        b_m = -500;
        biasData    = BW'(b_m);
        biasWriteEn = 1'b1;
        w_m[5]      = -7000;
        colAddr     = AW'(5);
        colData     = BW'(w_m[5]);
        colWriteEn  = 1'b1;
        run_vec("same_cycle_write", 1'b0);

        // Reset in the middle of MAC at col 5
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 700; h_m[k] = 300; end
        b_m = 5;
        write_w(); write_b();
        drive_h();
        hiddenValid = 1'b1;
        step();
        hiddenValid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_output", $signed(outputVec), 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", dataoutReady, 0);
        ready_seen = 0;
        repeat (25) begin
            if (dataoutReady === 1'b1) ready_seen++;
            step();
        end
        check("midrst_no_ready", ready_seen, 0);

        // Register file was cleared by reset
        for (int k = 0; k < int'(H); k++) begin w_m[k] = 0; h_m[k] = 1000 + k; end
        b_m = 0;
        run_vec("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
